// File: rtl/field_packer_pkg.sv
// field_packer_pkg: shared widths and FSM state type for the field packer.
package field_packer_pkg;

  localparam int unsigned PACK_W     = 8;
  localparam int unsigned PACK_F     = 5;
  // Bit counter must represent 0..2W inclusive.
  localparam int unsigned PACK_CNT_W = $clog2(2 * PACK_W + 1);

  typedef enum logic {
    PACK,
    FLUSH
  } packer_state_t;

endpackage

// File: rtl/field_packer_if.sv
// field_packer_if: field-side and byte-side handshakes of the field packer.
// FIELD_PACKER_PARITY_EN adds ByteParity (even-parity XOR of ByteOut).
interface field_packer_if
  import field_packer_pkg::*;
  ();

  logic [PACK_F-1:0] FieldIn;
  logic              FieldValid;
  logic              FieldReady;
  logic              Flush;
  logic              FlushDone;
  logic [PACK_W-1:0] ByteOut;
  logic              ByteValid;
  logic              ByteReady;
`ifdef FIELD_PACKER_PARITY_EN
  logic              ByteParity;

  modport slave (
    input  FieldIn, FieldValid, Flush, ByteReady,
    output FieldReady, FlushDone, ByteOut, ByteValid, ByteParity
  );

  modport master (
    output FieldIn, FieldValid, Flush, ByteReady,
    input  FieldReady, FlushDone, ByteOut, ByteValid, ByteParity
  );
`else
  modport slave (
    input  FieldIn, FieldValid, Flush, ByteReady,
    output FieldReady, FlushDone, ByteOut, ByteValid
  );

  modport master (
    output FieldIn, FieldValid, Flush, ByteReady,
    input  FieldReady, FlushDone, ByteOut, ByteValid
  );
`endif

endinterface

// File: rtl/field_pack_acc.sv
// field_pack_acc: MSB-aligned bit accumulator with push (insert field) and
// pop (remove top byte) strobes; both may fire in the same cycle.
module field_pack_acc
  import field_packer_pkg::*;
#(
  parameter int unsigned W     = PACK_W,
  parameter int unsigned F     = PACK_F,
  parameter int unsigned CNT_W = PACK_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [F-1:0]     field_i,
  output logic [2*W-1:0]   acc_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_shift;
  logic [2*W-1:0]   field_ins;
  logic [CNT_W-1:0] cnt_base;

  // Shift out the popped byte first, then OR the field in below the surviving
  // bits; a partial pop (fewer than W bits left) empties the count to zero.
  always_comb begin
    acc_shift = acc_q;
    cnt_base  = cnt_q;
    if (pop_i) begin
      acc_shift = acc_q << W;
      cnt_base  = (cnt_q >= CNT_W'(W)) ? (cnt_q - CNT_W'(W)) : '0;
    end
    field_ins = {field_i, {(2*W-F){1'b0}}} >> cnt_base;
    acc_d     = acc_shift;
    cnt_d     = cnt_base;
    if (push_i) begin
      acc_d = acc_shift | field_ins;
      cnt_d = cnt_base + CNT_W'(F);
    end
  end

  // Accumulator and bit-count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o = acc_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/field_packer.sv
// field_packer: packs F-bit fields MSB-first into W-bit bytes, with a flush
// that emits the zero-padded trailing byte. Optional FIELD_PACKER_PARITY_EN
// drives ByteParity = ^ByteOut.
module field_packer
  import field_packer_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  field_packer_if.slave  bus
);

  localparam int unsigned W     = PACK_W;
  localparam int unsigned F     = PACK_F;
  localparam int unsigned CNT_W = PACK_CNT_W;

  packer_state_t    state_q, state_d;
  logic [2*W-1:0]   acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             field_ready;
  logic             byte_valid;
  logic             flush_done;
  logic             push;
  logic             pop;

  field_pack_acc #(
    .W     (W),
    .F     (F),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .field_i (bus.FieldIn),
    .acc_o   (acc),
    .cnt_o   (bit_cnt)
  );

  // Handshake qualifiers derived only from registered state.
  always_comb begin
    field_ready = (state_q == PACK) && (bit_cnt <= CNT_W'(2*W-F));
    byte_valid  = (bit_cnt >= CNT_W'(W)) || ((state_q == FLUSH) && (bit_cnt != '0));
    flush_done  = (state_q == FLUSH) && (bit_cnt == '0);
    push        = bus.FieldValid && field_ready;
    pop         = byte_valid && bus.ByteReady;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= PACK;
    else        state_q <= state_d;
  end

  // FSM next state: enter FLUSH on request, leave once the accumulator is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PACK:    if (bus.Flush)       state_d = FLUSH;
      FLUSH:   if (bit_cnt == '0)   state_d = PACK;
      default:                      state_d = PACK;
    endcase
  end

  assign bus.FieldReady = field_ready;
  assign bus.ByteValid  = byte_valid;
  assign bus.FlushDone  = flush_done;
  assign bus.ByteOut    = acc[2*W-1:W];
`ifdef FIELD_PACKER_PARITY_EN
  assign bus.ByteParity = ^acc[2*W-1:W];
`endif

endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: directed self-checking bench for field_packer.
module tb_field_packer;

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;

  field_packer_if bus ();

  field_packer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.FieldIn = '0; bus.FieldValid = 1'b0; bus.Flush = 1'b0; bus.ByteReady = 1'b0;
    #3;
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL reset_bv: got %b want 0", bus.ByteValid); end
    n_tests++; if (bus.FieldReady !== 1'b1) begin n_fail++; $display("FAIL reset_fr: got %b want 1", bus.FieldReady); end
    n_tests++; if (bus.FlushDone !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", bus.FlushDone); end
    n_tests++; if (bus.ByteOut !== 8'h00) begin n_fail++; $display("FAIL reset_bo: got %h want 00", bus.ByteOut); end
`ifdef FIELD_PACKER_PARITY_EN
    n_tests++; if (bus.ByteParity !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b want 0", bus.ByteParity); end
`endif
    tick();
    tick();
    #2 Reset = 1'b1;
    tick();
  endtask

  task automatic test_pair_flush();
    bus.ByteReady = 1'b1;
    bus.FieldValid = 1'b1; bus.FieldIn = 5'b10110;
    tick();
    bus.FieldIn = 5'b01101;
    tick();
    n_tests++; if (bus.ByteValid !== 1'b1) begin n_fail++; $display("FAIL pair_bv0: got %b want 1", bus.ByteValid); end
    n_tests++; if (bus.ByteOut !== 8'hB3) begin n_fail++; $display("FAIL pair_b0: got %h want b3", bus.ByteOut); end
`ifdef FIELD_PACKER_PARITY_EN
    n_tests++; if (bus.ByteParity !== 1'b1) begin n_fail++; $display("FAIL pair_par0: got %b want 1", bus.ByteParity); end
`endif
    bus.FieldValid = 1'b0; bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    n_tests++; if (bus.ByteValid !== 1'b1) begin n_fail++; $display("FAIL pair_bv1: got %b want 1", bus.ByteValid); end
    n_tests++; if (bus.ByteOut !== 8'h40) begin n_fail++; $display("FAIL pair_b1: got %h want 40", bus.ByteOut); end
    n_tests++; if (bus.FlushDone !== 1'b0) begin n_fail++; $display("FAIL pair_fd_early: got %b want 0", bus.FlushDone); end
`ifdef FIELD_PACKER_PARITY_EN
    n_tests++; if (bus.ByteParity !== 1'b1) begin n_fail++; $display("FAIL pair_par1: got %b want 1", bus.ByteParity); end
`endif
    tick();
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL pair_bv2: got %b want 0", bus.ByteValid); end
    n_tests++; if (bus.FlushDone !== 1'b1) begin n_fail++; $display("FAIL pair_fd: got %b want 1", bus.FlushDone); end
    n_tests++; if (bus.FieldReady !== 1'b0) begin n_fail++; $display("FAIL pair_fr_flush: got %b want 0", bus.FieldReady); end
    tick();
    n_tests++; if (bus.FlushDone !== 1'b0) begin n_fail++; $display("FAIL pair_fd_pulse: got %b want 0", bus.FlushDone); end
    n_tests++; if (bus.FieldReady !== 1'b1) begin n_fail++; $display("FAIL pair_fr_back: got %b want 1", bus.FieldReady); end
  endtask

  task automatic test_back_to_back();
    int model_cnt = 0;
    int sent = 0;
    int nbytes = 0;
    int cyc = 0;
    logic exp_ready, exp_bv, do_push;
    bus.ByteReady = 1'b1;
    bus.FieldIn = 5'b11111;
    while ((sent < 8 || model_cnt != 0) && cyc < 40) begin
      bus.FieldValid = (sent < 8);
      exp_ready = (model_cnt <= 11);
      exp_bv    = (model_cnt >= 8);
      n_tests++; if (bus.FieldReady !== exp_ready) begin n_fail++; $display("FAIL b2b_fr cyc%0d: got %b want %b", cyc, bus.FieldReady, exp_ready); end
      n_tests++; if (bus.ByteValid !== exp_bv) begin n_fail++; $display("FAIL b2b_bv cyc%0d: got %b want %b", cyc, bus.ByteValid, exp_bv); end
      if (exp_bv) begin
        nbytes++;
        n_tests++; if (bus.ByteOut !== 8'hFF) begin n_fail++; $display("FAIL b2b_byte cyc%0d: got %h want ff", cyc, bus.ByteOut); end
`ifdef FIELD_PACKER_PARITY_EN
        n_tests++; if (bus.ByteParity !== 1'b0) begin n_fail++; $display("FAIL b2b_par cyc%0d: got %b want 0", cyc, bus.ByteParity); end
`endif
      end
      do_push = bus.FieldValid && exp_ready;
      model_cnt = model_cnt + (do_push ? 5 : 0) - (exp_bv ? 8 : 0);
      if (do_push) sent++;
      tick();
      cyc++;
    end
    bus.FieldValid = 1'b0;
    n_tests++; if (nbytes != 5) begin n_fail++; $display("FAIL b2b_nbytes: got %0d want 5", nbytes); end
    n_tests++; if (sent != 8) begin n_fail++; $display("FAIL b2b_sent: got %0d want 8", sent); end
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL b2b_flush_bv: got %b want 0", bus.ByteValid); end
    n_tests++; if (bus.FlushDone !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_fd: got %b want 1", bus.FlushDone); end
    tick();
    n_tests++; if (bus.FlushDone !== 1'b0) begin n_fail++; $display("FAIL b2b_flush_pulse: got %b want 0", bus.FlushDone); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    bus.ByteReady = 1'b0;
    bus.FieldValid = 1'b1; bus.FieldIn = 5'b11111;
    for (int i = 0; i < 8; i++) begin
      if (bus.FieldReady === 1'b1) accepted++;
      tick();
    end
    n_tests++; if (accepted != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", accepted); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (bus.FieldReady !== 1'b0) begin n_fail++; $display("FAIL bp_fr%0d: got %b want 0", i, bus.FieldReady); end
      n_tests++; if (bus.ByteValid !== 1'b1) begin n_fail++; $display("FAIL bp_bv%0d: got %b want 1", i, bus.ByteValid); end
      n_tests++; if (bus.ByteOut !== 8'hFF) begin n_fail++; $display("FAIL bp_hold%0d: got %h want ff", i, bus.ByteOut); end
      tick();
    end
    bus.FieldValid = 1'b0;
    bus.Flush = 1'b1; bus.ByteReady = 1'b1;
    tick();
    bus.Flush = 1'b0;
    n_tests++; if (bus.ByteValid !== 1'b1) begin n_fail++; $display("FAIL bp_tail_bv: got %b want 1", bus.ByteValid); end
    n_tests++; if (bus.ByteOut !== 8'hFE) begin n_fail++; $display("FAIL bp_tail: got %h want fe", bus.ByteOut); end
`ifdef FIELD_PACKER_PARITY_EN
    n_tests++; if (bus.ByteParity !== 1'b1) begin n_fail++; $display("FAIL bp_tail_par: got %b want 1", bus.ByteParity); end
`endif
    tick();
    n_tests++; if (bus.FlushDone !== 1'b1) begin n_fail++; $display("FAIL bp_fd: got %b want 1", bus.FlushDone); end
    tick();
  endtask

  task automatic test_flush_empty();
    bus.ByteReady = 1'b1;
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL fe_bv_pre: got %b want 0", bus.ByteValid); end
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL fe_bv: got %b want 0", bus.ByteValid); end
    n_tests++; if (bus.FlushDone !== 1'b1) begin n_fail++; $display("FAIL fe_fd: got %b want 1", bus.FlushDone); end
    tick();
    n_tests++; if (bus.FlushDone !== 1'b0) begin n_fail++; $display("FAIL fe_fd_pulse: got %b want 0", bus.FlushDone); end
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL fe_bv_post: got %b want 0", bus.ByteValid); end
  endtask

  task automatic test_reset_mid();
    bus.ByteReady = 1'b0;
    bus.FieldValid = 1'b1; bus.FieldIn = 5'b10110;
    tick();
    bus.FieldIn = 5'b01101;
    tick();
    bus.FieldValid = 1'b0;
    n_tests++; if (bus.ByteValid !== 1'b1) begin n_fail++; $display("FAIL rm_bv_pre: got %b want 1", bus.ByteValid); end
    #2 Reset = 1'b0;
    #1;
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL rm_bv: got %b want 0", bus.ByteValid); end
    n_tests++; if (bus.FieldReady !== 1'b1) begin n_fail++; $display("FAIL rm_fr: got %b want 1", bus.FieldReady); end
    n_tests++; if (bus.ByteOut !== 8'h00) begin n_fail++; $display("FAIL rm_bo: got %h want 00", bus.ByteOut); end
    #2 Reset = 1'b1;
    bus.FieldValid = 1'b1; bus.FieldIn = 5'b10101;
    tick();
    bus.FieldValid = 1'b0;
    n_tests++; if (bus.ByteOut !== 8'hA8) begin n_fail++; $display("FAIL rm_land: got %h want a8", bus.ByteOut); end
    n_tests++; if (bus.ByteValid !== 1'b0) begin n_fail++; $display("FAIL rm_land_bv: got %b want 0", bus.ByteValid); end
    bus.Flush = 1'b1; bus.ByteReady = 1'b1;
    tick();
    bus.Flush = 1'b0;
    n_tests++; if (bus.ByteValid !== 1'b1) begin n_fail++; $display("FAIL rm_tail_bv: got %b want 1", bus.ByteValid); end
    n_tests++; if (bus.ByteOut !== 8'hA8) begin n_fail++; $display("FAIL rm_tail: got %h want a8", bus.ByteOut); end
    tick();
    n_tests++; if (bus.FlushDone !== 1'b1) begin n_fail++; $display("FAIL rm_fd: got %b want 1", bus.FlushDone); end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_pair_flush();
    test_back_to_back();
    test_backpressure();
    test_flush_empty();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
